fbc_ddr_unpack: RTL and testbench

- Read-side counterpart of the FBC cache packer.
- Fetches 256-bit FBC records back from the DDR read path one word at a time.
- Splits each record into four 64-bit lanes, lane 0 first, and streams them to the aurora FBC link under almost-full back-pressure.
- Checks each lane header and recovers the W/X encoder values from lane 0.

---
 rtl/fbc_pkg.sv | 31 +++
 rtl/fbc_lane_check.sv | 30 +++
 rtl/fbc_ddr_unpack.sv | 141 ++++++++++++++
 tb/tb_fbc_ddr_unpack.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbc_pkg.sv
// Shared constants and FSM encoding for the FBC record pack/unpack path.
// A record is four 64-bit lanes; lane k occupies bits [64k+63:64k].
package fbc_pkg;

    localparam int FBC_LANE_W   = 64;
    localparam int FBC_LANE_NUM = 4;
    localparam int FBC_REC_W    = 256;
    localparam int FBC_IDX_W    = $clog2(FBC_LANE_NUM);

    localparam int FBC_TAG_BIT  = 63;
    localparam int FBC_IDX_MSB  = 62;
    localparam int FBC_IDX_LSB  = 61;

    localparam int QPD_MARK_MSB = 63;
    localparam int QPD_MARK_LSB = 56;
    localparam logic [7:0] QPD_MARK = 8'hFF;

    localparam int ENC_VAL_W    = 18;
    localparam int ENC_W_MSB    = 49;
    localparam int ENC_W_LSB    = 32;
    localparam int ENC_X_MSB    = 17;
    localparam int ENC_X_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } fbc_state_e;

endpackage

// File: rtl/fbc_lane_check.sv
// Combinational lane header checker: tagged format checks tag bit and lane
// index on every lane, QPD format checks only the lane-0 marker byte.
module fbc_lane_check
    import fbc_pkg::*;
(
    input  logic [FBC_LANE_W-1:0] i_lane,
    input  logic [FBC_IDX_W-1:0]  i_idx,
    input  logic                  i_qpd,
    output logic                  o_err
);

    logic w_unused;
    assign w_unused = ^i_lane[QPD_MARK_LSB-1:0];

    // Header compare for the selected record format
    always_comb begin
        o_err = 1'b0;
        if (i_qpd) begin
            if (i_idx == 2'd0) begin
                o_err = (i_lane[QPD_MARK_MSB:QPD_MARK_LSB] != QPD_MARK);
            end else begin
                o_err = 1'b0;
            end
        end else begin
            o_err = (i_lane[FBC_TAG_BIT] != 1'b1) ||
                    (i_lane[FBC_IDX_MSB:FBC_IDX_LSB] != i_idx);
        end
    end

endmodule

// File: rtl/fbc_ddr_unpack.sv
// Fetches 256-bit FBC records from the DDR read path, one request at a time,
// and streams them to the aurora link as four 64-bit lanes, lane 0 first.
module fbc_ddr_unpack
    import fbc_pkg::*;
#(
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_QPD_enable_i,
    input  logic                  fbc_rd_empty_i,
    output logic                  fbc_rd_seq_o,
    input  logic                  fbc_rd_vld_i,
    input  logic [FBC_REC_W-1:0]  fbc_rd_data_i,
    input  logic                  aurora_fbc_almost_full_i,
    output logic                  aurora_fbc_vout_vld_o,
    output logic [FBC_LANE_W-1:0] aurora_fbc_vout_data_o,
    output logic [ENC_VAL_W-1:0]  encode_w_o,
    output logic [ENC_VAL_W-1:0]  encode_x_o,
    output logic                  hdr_err_o,
    output logic [15:0]           hdr_err_cnt_o,
    output logic                  rd_timeout_o,
    output logic [31:0]           rec_cnt_o
);

    localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

    fbc_state_e            r_state;
    logic [CNT_W-1:0]      r_to_cnt;
    logic [FBC_REC_W-1:0]  r_rec;
    logic [FBC_IDX_W-1:0]  r_idx;
    logic                  r_qpd;
    logic                  r_seq;
    logic                  r_vout_vld;
    logic [FBC_LANE_W-1:0] r_vout_data;
    logic [ENC_VAL_W-1:0]  r_enc_w;
    logic [ENC_VAL_W-1:0]  r_enc_x;
    logic                  r_hdr_err;
    logic [15:0]           r_hdr_err_cnt;
    logic                  r_timeout;
    logic [31:0]           r_rec_cnt;

    logic [FBC_LANE_W-1:0] w_lane;
    logic                  w_lane_err;
    logic [CNT_W-1:0]      w_to_nxt;

    assign w_lane   = r_rec[{r_idx, 6'd0} +: FBC_LANE_W];
    // Timeout fires on the cycle the counter steps onto RD_TIMEOUT-1
    assign w_to_nxt = r_to_cnt + CNT_W'(1);

    fbc_lane_check u_lane_check (
        .i_lane (w_lane),
        .i_idx  (r_idx),
        .i_qpd  (r_qpd),
        .o_err  (w_lane_err)
    );

    // Request/wait/send sequencer with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_to_cnt      <= CNT_W'(0);
            r_rec         <= {FBC_REC_W{1'b0}};
            r_idx         <= 2'd0;
            r_qpd         <= 1'b0;
            r_seq         <= 1'b0;
            r_vout_vld    <= 1'b0;
            r_vout_data   <= 64'd0;
            r_enc_w       <= 18'd0;
            r_enc_x       <= 18'd0;
            r_hdr_err     <= 1'b0;
            r_hdr_err_cnt <= 16'd0;
            r_timeout     <= 1'b0;
            r_rec_cnt     <= 32'd0;
        end else begin
            r_seq      <= 1'b0;
            r_vout_vld <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!fbc_rd_empty_i && !aurora_fbc_almost_full_i) begin
                        r_seq   <= 1'b1;
                        r_state <= ST_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    r_to_cnt <= CNT_W'(0);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_to_cnt <= w_to_nxt;
                    if (fbc_rd_vld_i) begin
                        r_rec   <= fbc_rd_data_i;
                        r_idx   <= 2'd0;
                        r_qpd   <= cfg_QPD_enable_i;
                        r_enc_w <= fbc_rd_data_i[ENC_W_MSB:ENC_W_LSB];
                        r_enc_x <= fbc_rd_data_i[ENC_X_MSB:ENC_X_LSB];
                        r_state <= ST_SEND;
                    end else if (w_to_nxt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_SEND: begin
                    if (!aurora_fbc_almost_full_i) begin
                        r_vout_vld  <= 1'b1;
                        r_vout_data <= w_lane;
                        r_hdr_err   <= w_lane_err;
                        if (w_lane_err && (r_hdr_err_cnt != 16'hFFFF)) begin
                            r_hdr_err_cnt <= r_hdr_err_cnt + 16'd1;
                        end
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'(FBC_LANE_NUM - 1)) begin
                            r_rec_cnt <= r_rec_cnt + 32'd1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fbc_rd_seq_o           = r_seq;
    assign aurora_fbc_vout_vld_o  = r_vout_vld;
    assign aurora_fbc_vout_data_o = r_vout_data;
    assign encode_w_o             = r_enc_w;
    assign encode_x_o             = r_enc_x;
    assign hdr_err_o              = r_hdr_err;
    assign hdr_err_cnt_o          = r_hdr_err_cnt;
    assign rd_timeout_o           = r_timeout;
    assign rec_cnt_o              = r_rec_cnt;

endmodule

// File: tb/tb_fbc_ddr_unpack.sv
// Directed bench for fbc_ddr_unpack: latency, header errors, back-pressure,
// read timeout, QPD encoder extraction and reset in mid-record.
module tb_fbc_ddr_unpack;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg;
    logic         empty;
    logic         seq;
    logic         vld;
    logic [255:0] data;
    logic         af;
    logic         vout_vld;
    logic [63:0]  vout_data;
    logic [17:0]  enc_w;
    logic [17:0]  enc_x;
    logic         hdr_err;
    logic [15:0]  hdr_cnt;
    logic         to;
    logic [31:0]  rcnt;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    fbc_ddr_unpack #(.RD_TIMEOUT(64)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .cfg_QPD_enable_i         (cfg),
        .fbc_rd_empty_i           (empty),
        .fbc_rd_seq_o             (seq),
        .fbc_rd_vld_i             (vld),
        .fbc_rd_data_i            (data),
        .aurora_fbc_almost_full_i (af),
        .aurora_fbc_vout_vld_o    (vout_vld),
        .aurora_fbc_vout_data_o   (vout_data),
        .encode_w_o               (enc_w),
        .encode_x_o               (enc_x),
        .hdr_err_o                (hdr_err),
        .hdr_err_cnt_o            (hdr_cnt),
        .rd_timeout_o             (to),
        .rec_cnt_o                (rcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Waits for a request, then drives vld 'gap' cycles after the REQ cycle.
    // Returns at the negedge of the vld cycle n with vld still high.
    task automatic issue_record(input logic [255:0] rec, input int gap,
                                output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        empty = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        empty = 1'b1;
        if (ok) begin
            repeat (gap) @(negedge clk);
            vld = 1'b1;
            data = rec;
            n = cyc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg = 1'b0; empty = 1'b1; vld = 1'b0; data = '0; af = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (vout_vld !== 1'b0 || seq !== 1'b0 || hdr_err !== 1'b0 || to !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: vld=%b seq=%b err=%b to=%b, want all 0", vout_vld, seq, hdr_err, to);
        end
        total++;
        if (hdr_cnt !== 16'd0 || rcnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: hdr_cnt=%0d rec_cnt=%0d, want 0 0", hdr_cnt, rcnt);
        end
        total++;
        if (enc_w !== 18'd0 || enc_x !== 18'd0 || vout_data !== 64'd0) begin
            bad++;
            $display("FAIL reset_data: w=%h x=%h data=%h, want 0", enc_w, enc_x, vout_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] la [4];
        int exp_idx [8] = '{-1, -1, 0, 1, 2, 3, -1, -1};
        int n; bit ok; bit exp_v; logic [63:0] exp_d;
        la = '{64'h8123_4567_89AB_CDEF, 64'hA000_0000_0000_0011,
               64'hC000_0000_0000_0022, 64'hE000_0000_0000_0033};
        cfg = 1'b0;
        issue_record({la[3], la[2], la[1], la[0]}, 2, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_req: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            vld = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? la[exp_idx[j]] : 64'd0;
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d) || hdr_err !== 1'b0 ||
                seq !== 1'b0 || to !== 1'b0) begin
                bad++;
                $display("FAIL basic_lane N+%0d: vld=%b data=%h err=%b seq=%b to=%b, want vld=%b data=%h err=0 seq=0 to=0",
                         j, vout_vld, vout_data, hdr_err, seq, to, exp_v, exp_d);
            end
        end
        total++;
        if (hdr_cnt !== 16'd0 || rcnt !== 32'd1) begin
            bad++;
            $display("FAIL basic_counts: hdr_cnt=%0d rec_cnt=%0d, want 0 1", hdr_cnt, rcnt);
        end
        total++;
        if (enc_w !== 18'h34567 || enc_x !== 18'h3CDEF) begin
            bad++;
            $display("FAIL basic_enc: w=%h x=%h, want 34567 3cdef", enc_w, enc_x);
        end
    endtask

    task automatic test_hdr_err();
        logic [63:0] la [4];
        int exp_idx [7] = '{-1, -1, 0, 1, 2, 3, -1};
        int n; bit ok; bit exp_v; bit exp_e; logic [63:0] exp_d;
        la = '{64'h8000_0000_0000_0010, 64'hA000_0000_0000_0011,
               64'hA000_0000_0000_0B22, 64'hE000_0000_0000_0B33};
        cfg = 1'b0;
        issue_record({la[3], la[2], la[1], la[0]}, 3, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hdr_req: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 7; j++) begin
            @(negedge clk);
            vld = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? la[exp_idx[j]] : 64'd0;
            exp_e = (exp_idx[j] == 2);
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d) || hdr_err !== exp_e) begin
                bad++;
                $display("FAIL hdr_lane N+%0d: vld=%b data=%h err=%b, want vld=%b data=%h err=%b",
                         j, vout_vld, vout_data, hdr_err, exp_v, exp_d, exp_e);
            end
        end
        total++;
        if (hdr_cnt !== 16'd1 || rcnt !== 32'd2) begin
            bad++;
            $display("FAIL hdr_counts: hdr_cnt=%0d rec_cnt=%0d, want 1 2", hdr_cnt, rcnt);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] la [4];
        int exp_idx [12] = '{-1, -1, 0, 1, -1, -1, -1, -1, -1, 2, 3, -1};
        int n; bit ok; bit exp_v; logic [63:0] exp_d;
        la = '{64'h8000_0001_0000_0002, 64'hA000_0000_0000_0101,
               64'hC000_0000_0000_0202, 64'hE000_0000_0000_0303};
        cfg = 1'b0;
        issue_record({la[3], la[2], la[1], la[0]}, 1, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_req: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 12; j++) begin
            @(negedge clk);
            vld = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? la[exp_idx[j]] : 64'd0;
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d) || hdr_err !== 1'b0) begin
                bad++;
                $display("FAIL bp_lane N+%0d: vld=%b data=%h err=%b, want vld=%b data=%h err=0",
                         j, vout_vld, vout_data, hdr_err, exp_v, exp_d);
            end
            af = (j >= 3 && j <= 7);
        end
        af = 1'b0;
        total++;
        if (rcnt !== 32'd3 || enc_w !== 18'h00001 || enc_x !== 18'h00002) begin
            bad++;
            $display("FAIL bp_end: rec_cnt=%0d w=%h x=%h, want 3 00001 00002", rcnt, enc_w, enc_x);
        end
    endtask

    task automatic test_timeout();
        int r; int t1; int t2; bit ok;
        ok = 1'b0; r = 0; t1 = -1000; t2 = -1000;
        empty = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seq === 1'b1) begin ok = 1'b1; r = cyc; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL to_req: no fbc_rd_seq_o pulse, want one"); end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (to === 1'b1) begin t1 = cyc; break; end
        end
        total++;
        if (t1 - r != 64) begin
            bad++;
            $display("FAIL to_delay: timeout %0d cycles after REQ, want 64", t1 - r);
        end
        @(negedge clk);
        total++;
        if (seq !== 1'b1 || to !== 1'b0) begin
            bad++;
            $display("FAIL to_rereq: seq=%b to=%b one cycle after timeout, want seq=1 to=0", seq, to);
        end
        r = cyc;
        empty = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (to === 1'b1) begin t2 = cyc; break; end
        end
        total++;
        if (t2 - r != 64) begin
            bad++;
            $display("FAIL to_delay2: timeout %0d cycles after REQ, want 64", t2 - r);
        end
        vld = 1'b1;
        data = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        repeat (2) @(negedge clk);
        vld = 1'b0;
        data = '0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (vout_vld !== 1'b0 || enc_w !== 18'h00001 || enc_x !== 18'h00002 || seq !== 1'b0) begin
                bad++;
                $display("FAIL idle_vld_ignored: vld=%b w=%h x=%h seq=%b, want 0 00001 00002 0",
                         vout_vld, enc_w, enc_x, seq);
            end
        end
    endtask

    task automatic test_qpd();
        logic [63:0] la [4];
        int exp_idx [7] = '{-1, -1, 0, 1, 2, 3, -1};
        int n; bit ok; bit exp_v; logic [63:0] exp_d;
        la = '{64'hFF02_ABCD_0000_1234, 64'h0123_4567_89AB_CDEF,
               64'h0000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
        cfg = 1'b1;
        // vld lands on the last WAIT cycle before the timeout would fire
        issue_record({la[3], la[2], la[1], la[0]}, 63, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL qpd_req: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 7; j++) begin
            @(negedge clk);
            vld = 1'b0;
            cfg = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? la[exp_idx[j]] : 64'd0;
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d) || hdr_err !== 1'b0 || to !== 1'b0) begin
                bad++;
                $display("FAIL qpd_lane N+%0d: vld=%b data=%h err=%b to=%b, want vld=%b data=%h err=0 to=0",
                         j, vout_vld, vout_data, hdr_err, to, exp_v, exp_d);
            end
        end
        total++;
        if (enc_w !== 18'h2ABCD || enc_x !== 18'h01234) begin
            bad++;
            $display("FAIL qpd_enc: w=%h x=%h, want 2abcd 01234", enc_w, enc_x);
        end
        total++;
        if (hdr_cnt !== 16'd1 || rcnt !== 32'd4) begin
            bad++;
            $display("FAIL qpd_counts: hdr_cnt=%0d rec_cnt=%0d, want 1 4", hdr_cnt, rcnt);
        end
    endtask

    task automatic test_reset_in_send();
        logic [63:0] la [4];
        logic [63:0] lb [4];
        int exp_idx [7] = '{-1, -1, 0, 1, 2, 3, -1};
        int n; bit ok; bit exp_v; logic [63:0] exp_d;
        la = '{64'h8000_0000_0000_00D0, 64'hA000_0000_0000_00D1,
               64'hC000_0000_0000_00D2, 64'hE000_0000_0000_00D3};
        lb = '{64'h8000_0000_0000_00E0, 64'hA000_0000_0000_00E1,
               64'hC000_0000_0000_00E2, 64'hE000_0000_0000_00E3};
        cfg = 1'b0;
        issue_record({la[3], la[2], la[1], la[0]}, 2, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_req: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            vld = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? la[exp_idx[j]] : 64'd0;
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d)) begin
                bad++;
                $display("FAIL rst_pre_lane N+%0d: vld=%b data=%h, want vld=%b data=%h",
                         j, vout_vld, vout_data, exp_v, exp_d);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (vout_vld !== 1'b0 || rcnt !== 32'd0 || hdr_cnt !== 16'd0 || enc_w !== 18'd0) begin
            bad++;
            $display("FAIL rst_mid: vld=%b rec_cnt=%0d hdr_cnt=%0d w=%h, want 0 0 0 0",
                     vout_vld, rcnt, hdr_cnt, enc_w);
        end
        rst = 1'b0;
        issue_record({lb[3], lb[2], lb[1], lb[0]}, 2, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_req2: no fbc_rd_seq_o pulse, want one"); end
        for (int j = 1; j < 7; j++) begin
            @(negedge clk);
            vld = 1'b0;
            exp_v = (exp_idx[j] >= 0);
            exp_d = exp_v ? lb[exp_idx[j]] : 64'd0;
            total++;
            if (vout_vld !== exp_v || (exp_v && vout_data !== exp_d) || hdr_err !== 1'b0) begin
                bad++;
                $display("FAIL rst_post_lane N+%0d: vld=%b data=%h err=%b, want vld=%b data=%h err=0",
                         j, vout_vld, vout_data, hdr_err, exp_v, exp_d);
            end
        end
        total++;
        if (rcnt !== 32'd1 || hdr_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_post_counts: rec_cnt=%0d hdr_cnt=%0d, want 1 0", rcnt, hdr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hdr_err();
        test_backpressure();
        test_timeout();
        test_qpd();
        test_reset_in_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
